// File: rtl/cordic_pkg.sv
// Shared constants for the pipelined CORDIC engine: arctangent table,
// per-sample mode encoding and the 1/K gain used by gain compensation.
package cordic_pkg;

    typedef enum logic {
        MODE_ROT = 1'b0,
        MODE_VEC = 1'b1
    } mode_e;

    // round(atan(2^-i) * 2^10)
    localparam int ATAN_Q10 [32] = '{
        804, 475, 251, 127, 64, 32, 16, 8,
        4, 2, 1, 0, 0, 0, 0, 0,
        0, 0, 0, 0, 0, 0, 0, 0,
        0, 0, 0, 0, 0, 0, 0, 0
    };

    // 1/K as an unsigned Q0.32 fraction
    localparam logic [63:0] INV_K_Q32 = 64'd2608131496;

    function automatic int atan_q(input int i, input int frac);
        int v;
        v = ATAN_Q10[i];
        if (frac >= 10) begin
            return v <<< (frac - 10);
        end
        return (v + (1 <<< (9 - frac))) >>> (10 - frac);
    endfunction

    function automatic logic [63:0] gain_q(input int w);
        if (w >= 34) begin
            return INV_K_Q32 << (w - 34);
        end
        return (INV_K_Q32 + (64'd1 << (33 - w))) >> (34 - w);
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// One CORDIC micro-rotation: combinational shift/add feeding a register
// that holds valid, mode and x/y/z, advancing only when the pipe moves.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int                 WIDTH = 32,
    parameter int                 SHIFT = 0,
    parameter logic signed [WIDTH-1:0] ATAN = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    adv,
    input  logic                    valid,
    input  mode_e                   mode,
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] y,
    input  logic signed [WIDTH-1:0] z,
    output logic                    valid_q,
    output mode_e                   mode_q,
    output logic signed [WIDTH-1:0] x_q,
    output logic signed [WIDTH-1:0] y_q,
    output logic signed [WIDTH-1:0] z_q
);

    logic                    pos;
    logic signed [WIDTH-1:0] xs;
    logic signed [WIDTH-1:0] ys;

    always_comb begin
        xs  = x >>> SHIFT;
        ys  = y >>> SHIFT;
        pos = (mode == MODE_VEC) ? y[WIDTH-1] : !z[WIDTH-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            mode_q  <= MODE_ROT;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
        end else if (adv) begin
            valid_q <= valid;
            mode_q  <= mode;
            x_q     <= pos ? x - ys : x + ys;
            y_q     <= pos ? y + xs : y - xs;
            z_q     <= pos ? z - ATAN : z + ATAN;
        end
    end

endmodule

// File: rtl/cordic_pipe.sv
// Fully pipelined CORDIC (rotation/vectoring) with valid/ready flow control.
// Define CORDIC_GAIN_COMP_EN to add a registered 1/K gain-compensation stage.
module cordic_pipe
    import cordic_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 16,
    parameter int FRAC   = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_mode,
    input  logic signed [WIDTH-1:0] x0,
    input  logic signed [WIDTH-1:0] y0,
    input  logic signed [WIDTH-1:0] z0,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_mode,
    output logic signed [WIDTH-1:0] x,
    output logic signed [WIDTH-1:0] y,
    output logic signed [WIDTH-1:0] z
);

    logic adv;

    logic                    sv [STAGES+1];
    mode_e                   sm [STAGES+1];
    logic signed [WIDTH-1:0] sx [STAGES+1];
    logic signed [WIDTH-1:0] sy [STAGES+1];
    logic signed [WIDTH-1:0] sz [STAGES+1];

    logic                    fv;
    mode_e                   fm;
    logic signed [WIDTH-1:0] fx;
    logic signed [WIDTH-1:0] fy;
    logic signed [WIDTH-1:0] fz;

    // Whole pipe moves in lockstep; a stalled output freezes every stage.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign sv[0] = in_valid;
    assign sm[0] = mode_e'(in_mode);
    assign sx[0] = x0;
    assign sy[0] = y0;
    assign sz[0] = z0;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        cordic_stage #(
            .WIDTH (WIDTH),
            .SHIFT (i),
            .ATAN  (WIDTH'(atan_q(i, FRAC)))
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .adv     (adv),
            .valid   (sv[i]),
            .mode    (sm[i]),
            .x       (sx[i]),
            .y       (sy[i]),
            .z       (sz[i]),
            .valid_q (sv[i+1]),
            .mode_q  (sm[i+1]),
            .x_q     (sx[i+1]),
            .y_q     (sy[i+1]),
            .z_q     (sz[i+1])
        );
    end

`ifdef CORDIC_GAIN_COMP_EN
    localparam logic [63:0] GQ = gain_q(WIDTH);
    localparam logic signed [2*WIDTH-1:0] G = (2*WIDTH)'(GQ);

    logic signed [2*WIDTH-1:0] px;
    logic signed [2*WIDTH-1:0] py;

    assign px = (2*WIDTH)'(sx[STAGES]) * G;
    assign py = (2*WIDTH)'(sy[STAGES]) * G;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fv <= 1'b0;
            fm <= MODE_ROT;
            fx <= '0;
            fy <= '0;
            fz <= '0;
        end else if (adv) begin
            fv <= sv[STAGES];
            fm <= sm[STAGES];
            fx <= WIDTH'(px >>> (WIDTH - 2));
            fy <= WIDTH'(py >>> (WIDTH - 2));
            fz <= sz[STAGES];
        end
    end
`else
    assign fv = sv[STAGES];
    assign fm = sm[STAGES];
    assign fx = sx[STAGES];
    assign fy = sy[STAGES];
    assign fz = sz[STAGES];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_mode  <= 1'b0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
        end else if (adv) begin
            out_valid <= fv;
            out_mode  <= fm;
            x         <= fx;
            y         <= fy;
            z         <= fz;
        end
    end

endmodule

// File: tb/tb_cordic_pipe.sv
// Directed and streaming checks for cordic_pipe against a real-valued
// rotation/vectoring model; build with CORDIC_GAIN_COMP_EN for gain mode.
module tb_cordic_pipe;

    localparam int W = 32;
    localparam int S = 16;
    localparam int F = 10;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT = S + 2;
    localparam bit GC  = 1'b1;
`else
    localparam int LAT = S + 1;
    localparam bit GC  = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic in_mode = 1'b0;
    logic signed [W-1:0] x0 = '0;
    logic signed [W-1:0] y0 = '0;
    logic signed [W-1:0] z0 = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic out_mode;
    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    logic signed [W-1:0] z;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    real kg;

    int ax [100];
    int ay [100];
    int az [100];
    bit am [100];
    int qx [$];
    int qy [$];
    int qz [$];
    bit qm [$];

    cordic_pipe #(.WIDTH(W), .STAGES(S), .FRAC(F)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .x0        (x0),
        .y0        (y0),
        .z0        (z0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mode  (out_mode),
        .x         (x),
        .y         (y),
        .z         (z)
    );

    always #5 clk = ~clk;

    function automatic real kgain();
        real k = 1.0;
        for (int i = 0; i < S; i++) k = k * $sqrt(1.0 + $pow(2.0, -2.0 * i));
        return k;
    endfunction

    function automatic real sc();
        return GC ? 1.0 : kg;
    endfunction

    function automatic real ex_f(bit m, int a, int b, int c);
        real r = $itor(c) / 1024.0;
        if (m) return sc() * $sqrt($itor(a) * a + $itor(b) * b);
        return sc() * (a * $cos(r) - b * $sin(r));
    endfunction

    function automatic real ey_f(bit m, int a, int b, int c);
        real r = $itor(c) / 1024.0;
        if (m) return 0.0;
        return sc() * (a * $sin(r) + b * $cos(r));
    endfunction

    function automatic real ez_f(bit m, int a, int b, int c);
        if (m) return c + $atan2($itor(b), $itor(a)) * 1024.0;
        return 0.0;
    endfunction

    function automatic real tol_f(int a, int b);
        return 0.01 * sc() * $sqrt($itor(a) * a + $itor(b) * b) + 24.0;
    endfunction

    function automatic bit bad(int v, real e, real t);
        return ($itor(v) > e + t) || ($itor(v) < e - t);
    endfunction

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic gen_samples(input int n);
        for (int i = 0; i < n; i++) begin
            am[i] = 1'($urandom_range(0, 1));
            ay[i] = int'($urandom_range(0, 40000)) - 20000;
            if (am[i]) begin
                ax[i] = int'($urandom_range(1, 20000));
                az[i] = int'($urandom_range(0, 2000)) - 1000;
            end else begin
                ax[i] = int'($urandom_range(0, 40000)) - 20000;
                az[i] = int'($urandom_range(0, 3400)) - 1700;
            end
        end
    endtask

    task automatic load(input int k);
        in_valid = 1'b1;
        in_mode  = am[k];
        x0 = ax[k];
        y0 = ay[k];
        z0 = az[k];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b want=0", out_valid);
        end
        checks++;
        if (x !== 0 || y !== 0 || z !== 0) begin
            failures++;
            $display("FAIL reset_data got=%0d,%0d,%0d want=0,0,0", x, y, z);
        end
        checks++;
        if (out_mode !== 1'b0) begin
            failures++;
            $display("FAIL reset_mode got=%b want=0", out_mode);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b want=1", in_ready);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_directed(input string nm, input bit m,
                                 input int a, input int b, input int c,
                                 input int ex, input int ey, input int ez,
                                 input int tx, input int ty, input int tz);
        int acc;
        int lat;
        bit seen;
        out_ready = 1'b1;
        step();
        in_valid = 1'b1;
        in_mode = m;
        x0 = a;
        y0 = b;
        z0 = c;
        #1;
        acc = cyc + 1;
        step();
        in_valid = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 60; t++) begin
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        lat = cyc - acc + 1;
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_timeout got=no_output want=latency_%0d", nm, LAT);
        end else if (lat != LAT) begin
            failures++;
            $display("FAIL %s_latency got=%0d want=%0d", nm, lat, LAT);
        end
        if (seen) begin
            checks++;
            if (int'(x) > ex + tx || int'(x) < ex - tx) begin
                failures++;
                $display("FAIL %s_x got=%0d want=%0d+-%0d", nm, x, ex, tx);
            end
            checks++;
            if (int'(y) > ey + ty || int'(y) < ey - ty) begin
                failures++;
                $display("FAIL %s_y got=%0d want=%0d+-%0d", nm, y, ey, ty);
            end
            checks++;
            if (int'(z) > ez + tz || int'(z) < ez - tz) begin
                failures++;
                $display("FAIL %s_z got=%0d want=%0d+-%0d", nm, z, ez, tz);
            end
            checks++;
            if (out_mode !== m) begin
                failures++;
                $display("FAIL %s_mode got=%b want=%b", nm, out_mode, m);
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int got = 0;
        int first_acc = -1;
        int first_out = -1;
        bit took = 1'b0;
        bit gap = 1'b0;
        real t;
        gen_samples(100);
        out_ready = 1'b1;
        step();
        load(0);
        for (int it = 0; it < 200 && got < 100; it++) begin
            if (took) begin
                if (sent < 100) load(sent);
                else in_valid = 1'b0;
                took = 1'b0;
            end
            #1;
            if (got > 0 && out_valid !== 1'b1) gap = 1'b1;
            if (out_valid === 1'b1 && out_ready) begin
                if (first_out < 0) first_out = cyc;
                t = tol_f(qx[0], qy[0]);
                checks++;
                if (bad(int'(x), ex_f(qm[0], qx[0], qy[0], qz[0]), t) ||
                    bad(int'(y), ey_f(qm[0], qx[0], qy[0], qz[0]), t) ||
                    bad(int'(z), ez_f(qm[0], qx[0], qy[0], qz[0]), 6.0) ||
                    out_mode !== qm[0]) begin
                    failures++;
                    $display("FAIL b2b_sample%0d got=%0d,%0d,%0d,m%b want=%0.1f,%0.1f,%0.1f,m%b",
                             got, x, y, z, out_mode,
                             ex_f(qm[0], qx[0], qy[0], qz[0]),
                             ey_f(qm[0], qx[0], qy[0], qz[0]),
                             ez_f(qm[0], qx[0], qy[0], qz[0]), qm[0]);
                end
                void'(qx.pop_front());
                void'(qy.pop_front());
                void'(qz.pop_front());
                void'(qm.pop_front());
                got++;
            end
            if (in_valid && in_ready) begin
                if (first_acc < 0) first_acc = cyc + 1;
                qx.push_back(int'(x0));
                qy.push_back(int'(y0));
                qz.push_back(int'(z0));
                qm.push_back(in_mode);
                sent++;
                took = 1'b1;
            end
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (got != 100) begin
            failures++;
            $display("FAIL b2b_count got=%0d want=100", got);
        end
        checks++;
        if (gap) begin
            failures++;
            $display("FAIL b2b_continuous got=gap want=no_gap");
        end
        checks++;
        if (first_out - first_acc + 1 != LAT) begin
            failures++;
            $display("FAIL b2b_latency got=%0d want=%0d", first_out - first_acc + 1, LAT);
        end
    endtask

    task automatic test_stall();
        int sent = 0;
        int got = 0;
        bit took = 1'b0;
        logic signed [W-1:0] hx;
        logic signed [W-1:0] hy;
        logic signed [W-1:0] hz;
        real t;
        qx.delete();
        qy.delete();
        qz.delete();
        qm.delete();
        gen_samples(30);
        hx = '0;
        hy = '0;
        hz = '0;
        step();
        load(0);
        for (int it = 0; it < 150 && got < 30; it++) begin
            if (took) begin
                if (sent < 30) load(sent);
                else in_valid = 1'b0;
                took = 1'b0;
            end
            out_ready = !(it >= 25 && it < 30);
            #1;
            if (it == 25) begin
                hx = x;
                hy = y;
                hz = z;
            end
            if (!out_ready) begin
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_ready it=%0d got=in_ready%b,out_valid%b want=0,1",
                             it, in_ready, out_valid);
                end
            end
            if (it > 25 && it < 30) begin
                checks++;
                if (x !== hx || y !== hy || z !== hz) begin
                    failures++;
                    $display("FAIL stall_hold it=%0d got=%0d,%0d,%0d want=%0d,%0d,%0d",
                             it, x, y, z, hx, hy, hz);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                t = tol_f(qx[0], qy[0]);
                checks++;
                if (bad(int'(x), ex_f(qm[0], qx[0], qy[0], qz[0]), t) ||
                    bad(int'(y), ey_f(qm[0], qx[0], qy[0], qz[0]), t) ||
                    bad(int'(z), ez_f(qm[0], qx[0], qy[0], qz[0]), 6.0) ||
                    out_mode !== qm[0]) begin
                    failures++;
                    $display("FAIL stall_sample%0d got=%0d,%0d,%0d,m%b want=%0.1f,%0.1f,%0.1f,m%b",
                             got, x, y, z, out_mode,
                             ex_f(qm[0], qx[0], qy[0], qz[0]),
                             ey_f(qm[0], qx[0], qy[0], qz[0]),
                             ez_f(qm[0], qx[0], qy[0], qz[0]), qm[0]);
                end
                void'(qx.pop_front());
                void'(qy.pop_front());
                void'(qz.pop_front());
                void'(qm.pop_front());
                got++;
            end
            if (in_valid && in_ready) begin
                qx.push_back(int'(x0));
                qy.push_back(int'(y0));
                qz.push_back(int'(z0));
                qm.push_back(in_mode);
                sent++;
                took = 1'b1;
            end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != 30 || sent != 30) begin
            failures++;
            $display("FAIL stall_count got=out%0d,in%0d want=30,30", got, sent);
        end
        repeat (LAT + 4) step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_dup got=out_valid%b want=0", out_valid);
        end
    endtask

    task automatic test_reset_flight();
        int sent = 0;
        int leaked = 0;
        bit took = 1'b0;
        bit held = 1'b0;
        gen_samples(11);
        out_ready = 1'b0;
        step();
        load(0);
        for (int it = 0; it < 60; it++) begin
            if (took) begin
                if (sent < 11) load(sent);
                else in_valid = 1'b0;
                took = 1'b0;
            end
            #1;
            if (out_valid === 1'b1 && sent == 11) begin
                held = 1'b1;
                break;
            end
            if (in_valid && in_ready) begin
                sent++;
                took = 1'b1;
            end
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (!held) begin
            failures++;
            $display("FAIL rstfl_setup got=sent%0d,out_valid%b want=11,1", sent, out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || x !== 0) begin
            failures++;
            $display("FAIL rstfl_async got=out_valid%b,x%0d want=0,0", out_valid, x);
        end
        step();
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int it = 0; it < 40; it++) begin
            step();
            if (out_valid !== 1'b0) leaked++;
        end
        checks++;
        if (leaked != 0) begin
            failures++;
            $display("FAIL rstfl_leak got=%0d want=0", leaked);
        end
    endtask

    initial begin
        kg = kgain();
        test_reset();
        if (GC) begin
            test_directed("rot45", 1'b0, 1000, 0, 804, 707, 707, 0, 4, 4, 2);
            test_directed("vec45", 1'b1, 1000, 1000, 0, 1414, 0, 804, 8, 2, 2);
            test_directed("rot0", 1'b0, 1000, 0, 0, 1000, 0, 0, 3, 2, 2);
        end else begin
            test_directed("rot45", 1'b0, 1000, 0, 804, 1165, 1165, 0, 4, 4, 2);
            test_directed("vec45", 1'b1, 1000, 1000, 0, 2329, 0, 804, 8, 2, 2);
            test_directed("rot0", 1'b0, 1000, 0, 0, 1647, 0, 0, 4, 4, 2);
        end
        test_back_to_back();
        test_stall();
        test_reset_flight();
        if (GC) begin
            test_directed("post_rst", 1'b0, 1000, 0, 804, 707, 707, 0, 4, 4, 2);
        end else begin
            test_directed("post_rst", 1'b0, 1000, 0, 804, 1165, 1165, 0, 4, 4, 2);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
